// File: rtl/ctrl_decode_unit_pkg.sv
// Shared definitions for the decode/sequencer slice: field positions, opcodes,
// PC-update codes and the one-hot stage encoding.
package ctrl_decode_unit_pkg;

  localparam int INSTR_W = 16;
  localparam int IMM_W   = 8;
  localparam int SEL_W   = 3;
  localparam int OPC_W   = 4;
  localparam int ALUOP_W = 5;

  localparam int OPC_HI    = 15;
  localparam int OPC_LO    = 12;
  localparam int SELD_HI   = 11;
  localparam int SELD_LO   = 9;
  localparam int ALUOP_LSB = 8;
  localparam int SELA_HI   = 7;
  localparam int SELA_LO   = 5;
  localparam int SELB_HI   = 4;
  localparam int SELB_LO   = 2;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'd7;
  localparam logic [OPC_W-1:0] OP_JMPA = 4'd12;
  localparam logic [OPC_W-1:0] OP_JMPR = 4'd13;
  localparam logic [OPC_W-1:0] OP_LDW  = 4'd14;
  localparam logic [OPC_W-1:0] OP_STW  = 4'd15;

  typedef enum logic [1:0] {
    PCOP_HOLD  = 2'b00,
    PCOP_INC   = 2'b01,
    PCOP_LOAD  = 2'b10,
    PCOP_RESET = 2'b11
  } pcop_e;

  // One-hot so the stage enables are the state vector itself.
  typedef enum logic [5:0] {
    ST_FETCH    = 6'b000001,
    ST_DECODE   = 6'b000010,
    ST_REGREAD  = 6'b000100,
    ST_ALU      = 6'b001000,
    ST_MEM      = 6'b010000,
    ST_REGWRITE = 6'b100000
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0]   sel_d;
    logic [SEL_W-1:0]   sel_a;
    logic [SEL_W-1:0]   sel_b;
    logic [ALUOP_W-1:0] aluop;
    logic [IMM_W-1:0]   imme;
    logic               reg_we;
    logic               is_mem;
    logic               is_jmp;
    logic               is_store;
  } fields_t;

  function automatic logic opc_writes_reg(input logic [OPC_W-1:0] opc);
    logic we;
    case (opc)
      4'd6, OP_NOP, OP_JMPA, OP_JMPR, OP_STW: we = 1'b0;
      default:                                we = 1'b1;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/ctrl_decode_unit_instr_field_decode.sv
// Purely combinational split of an instruction word into its control fields.
module ctrl_decode_unit_instr_field_decode
  import ctrl_decode_unit_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output fields_t            fields_o
);

  logic [OPC_W-1:0] opc_s;

  assign opc_s = instr_i[OPC_HI:OPC_LO];

  // Field extraction and per-opcode qualifiers
  always_comb begin
    fields_o          = '0;
    fields_o.sel_d    = instr_i[SELD_HI:SELD_LO];
    fields_o.sel_a    = instr_i[SELA_HI:SELA_LO];
    fields_o.sel_b    = instr_i[SELB_HI:SELB_LO];
    fields_o.aluop    = {opc_s, instr_i[ALUOP_LSB]};
    fields_o.imme     = instr_i[IMM_HI:IMM_LO];
    fields_o.reg_we   = opc_writes_reg(opc_s);
    fields_o.is_mem   = (opc_s == OP_LDW) || (opc_s == OP_STW);
    fields_o.is_jmp   = (opc_s == OP_JMPA) || (opc_s == OP_JMPR);
    fields_o.is_store = (opc_s == OP_STW);
  end

endmodule

// File: rtl/ctrl_decode_unit.sv
// Instruction register, multi-cycle stage sequencer and PC-update control
// sitting in front of the ALU. All outputs are registered.
module ctrl_decode_unit
  import ctrl_decode_unit_pkg::*;
(
  input  logic               I_CLK,
  input  logic               I_RST,
  input  logic               I_EN,
  input  logic [INSTR_W-1:0] I_INSTR,
  input  logic               I_MEM_READY,
  input  logic               I_JMPBRANCH,
  output logic               O_EN_FETCH,
  output logic               O_EN_DECODE,
  output logic               O_EN_REGREAD,
  output logic               O_EN_ALU,
  output logic               O_EN_MEM,
  output logic               O_MEM_WE,
  output logic               O_EN_REGWRITE,
  output logic               O_REG_WE,
  output logic [SEL_W-1:0]   O_SEL_D,
  output logic [SEL_W-1:0]   O_SEL_A,
  output logic [SEL_W-1:0]   O_SEL_B,
  output logic [ALUOP_W-1:0] O_ALUOP,
  output logic [IMM_W-1:0]   O_IMME,
  output logic [1:0]         O_PCOP
);

  state_e             state_q, state_d;
  logic [5:0]         en_q, en_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  fields_t            fld_q, fld_d, dec_s;
  logic               mem_we_q, mem_we_d;
  pcop_e              pcop_q, pcop_d;

  ctrl_decode_unit_instr_field_decode u_field_decode (
    .instr_i  (ir_q),
    .fields_o (dec_s)
  );

  // Next state; en_q stays low after reset until the first enabled edge,
  // so a fetch is only accepted while the request is actually driven.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    ir_d     = ir_q;
    fld_d    = fld_q;
    mem_we_d = mem_we_q;
    pcop_d   = PCOP_HOLD;
    if (I_EN) begin
      case (state_q)
        ST_FETCH: begin
          if (en_q[0] && I_MEM_READY) begin
            state_d = ST_DECODE;
            ir_d    = I_INSTR;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_DECODE: begin
          state_d = ST_REGREAD;
          fld_d   = dec_s;
        end
        ST_REGREAD: state_d = ST_ALU;
        ST_ALU:     state_d = fld_q.is_mem ? ST_MEM : ST_REGWRITE;
        ST_MEM: begin
          if (I_MEM_READY) begin
            state_d = ST_REGWRITE;
          end else begin
            state_d = ST_MEM;
          end
        end
        ST_REGWRITE: state_d = ST_FETCH;
        default:     state_d = ST_FETCH;
      endcase
      en_d     = state_d;
      mem_we_d = (state_d == ST_MEM) && fld_q.is_store;
      if (state_d == ST_REGWRITE) begin
        pcop_d = (fld_q.is_jmp && I_JMPBRANCH) ? PCOP_LOAD : PCOP_INC;
      end else begin
        pcop_d = PCOP_HOLD;
      end
    end else begin
      pcop_d = PCOP_HOLD;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q  <= ST_FETCH;
      en_q     <= 6'b000000;
      ir_q     <= '0;
      fld_q    <= '0;
      mem_we_q <= 1'b0;
      pcop_q   <= PCOP_RESET;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      ir_q     <= ir_d;
      fld_q    <= fld_d;
      mem_we_q <= mem_we_d;
      pcop_q   <= pcop_d;
    end
  end

  assign O_EN_FETCH    = en_q[0];
  assign O_EN_DECODE   = en_q[1];
  assign O_EN_REGREAD  = en_q[2];
  assign O_EN_ALU      = en_q[3];
  assign O_EN_MEM      = en_q[4];
  assign O_EN_REGWRITE = en_q[5];
  assign O_MEM_WE      = mem_we_q;
  assign O_REG_WE      = fld_q.reg_we;
  assign O_SEL_D       = fld_q.sel_d;
  assign O_SEL_A       = fld_q.sel_a;
  assign O_SEL_B       = fld_q.sel_b;
  assign O_ALUOP       = fld_q.aluop;
  assign O_IMME        = fld_q.imme;
  assign O_PCOP        = pcop_q;

endmodule

// File: tb/tb_ctrl_decode_unit.sv
// Scoreboard bench for ctrl_decode_unit: the driver queues expected results
// per instruction, a monitor checks them when the write-back stage appears.
module tb_ctrl_decode_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, mem_ready, jmpbranch;
  logic [15:0] instr;
  logic        en_fetch, en_decode, en_regread, en_alu, en_mem, mem_we, en_regwrite, reg_we;
  logic [2:0]  sel_d, sel_a, sel_b;
  logic [4:0]  aluop;
  logic [7:0]  imme;
  logic [1:0]  pcop;
  logic [5:0]  en_vec;

  ctrl_decode_unit dut (
    .I_CLK(clk), .I_RST(rst), .I_EN(en), .I_INSTR(instr),
    .I_MEM_READY(mem_ready), .I_JMPBRANCH(jmpbranch),
    .O_EN_FETCH(en_fetch), .O_EN_DECODE(en_decode), .O_EN_REGREAD(en_regread),
    .O_EN_ALU(en_alu), .O_EN_MEM(en_mem), .O_MEM_WE(mem_we),
    .O_EN_REGWRITE(en_regwrite), .O_REG_WE(reg_we),
    .O_SEL_D(sel_d), .O_SEL_A(sel_a), .O_SEL_B(sel_b),
    .O_ALUOP(aluop), .O_IMME(imme), .O_PCOP(pcop)
  );

  assign en_vec = {en_regwrite, en_mem, en_alu, en_regread, en_decode, en_fetch};

  typedef struct {
    int sd; int sa; int sb; int op; int im; int we; int pc; int st; int cycles;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cnt = 0;
  int         wk;
  logic [5:0] prev_en = 6'b000000;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: fields by arithmetic on the word, rules from the opcode table
  function automatic exp_t model(input logic [15:0] ins, input logic br, input int mw);
    exp_t e;
    int w, opc;
    w        = int'(ins);
    opc      = w / 4096;
    e.sd     = (w / 512) % 8;
    e.sa     = (w / 32) % 8;
    e.sb     = (w / 4) % 8;
    e.op     = opc * 2 + (w / 256) % 2;
    e.im     = w % 256;
    e.we     = ((opc <= 5) || (opc >= 8 && opc <= 11) || opc == 14) ? 1 : 0;
    e.pc     = ((opc == 12 || opc == 13) && br) ? 2 : 1;
    e.st     = (opc == 15) ? 1 : 0;
    e.cycles = (opc >= 14) ? 5 + mw : 4;
    return e;
  endfunction

  // Drive one instruction: fw fetch waits, mw data waits, fz frozen cycles in REGREAD
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                           input logic br, input int fz);
    int  k, mc;
    bit  froze;
    k = 0;
    while (!en_fetch && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!en_fetch) begin
      fail_now("fetch_timeout");
      return;
    end
    exp_q.push_back(model(ins, br, mw));
    jmpbranch = br;
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0;
      instr     = 16'($urandom);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    instr     = ins;
    @(negedge clk);
    instr = 16'($urandom);
    mc = 0;
    froze = 1'b0;
    k = 0;
    while (!en_fetch && k < 60) begin
      if (en_mem) begin
        mem_ready = (mc == mw);
        mc++;
      end else begin
        mem_ready = 1'($urandom);
      end
      if (en_regread && !froze && fz > 0) begin
        en = 1'b0;
        repeat (fz) @(negedge clk);
        en = 1'b1;
        froze = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    mem_ready = 1'b0;
    if (!en_fetch) fail_now("instr_timeout");
  endtask

  // Monitor: reset state, one-hot, freeze hold, MEM strobe and write-back scoreboard
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("reset_enables", int'(en_vec), 0);
      chk("reset_pcop", int'(pcop), 3);
      chk("reset_fields", int'({sel_d, sel_a, sel_b, aluop, imme, reg_we, mem_we}), 0);
      cnt = 0;
    end else begin
      chk("onehot", $countones(en_vec), 1);
      if (!en) begin
        chk("freeze_hold", int'(en_vec), int'(prev_en));
        chk("freeze_pcop", int'(pcop), 0);
      end else begin
        if (en_decode) cnt = 1;
        else if (cnt > 0) cnt++;
        if (en_mem) begin
          if (exp_q.size() == 0) fail_now("mem_without_expectation");
          else chk("mem_we", int'(mem_we), exp_q[0].st);
        end
        if (en_regwrite) begin
          if (exp_q.size() == 0) begin
            fail_now("writeback_without_expectation");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sel_d", int'(sel_d), e.sd);
            chk("sel_a", int'(sel_a), e.sa);
            chk("sel_b", int'(sel_b), e.sb);
            chk("aluop", int'(aluop), e.op);
            chk("imme", int'(imme), e.im);
            chk("reg_we", int'(reg_we), e.we);
            chk("pcop_w", int'(pcop), e.pc);
            chk("latency", cnt, e.cycles);
          end
          cnt = 0;
        end else begin
          chk("pcop_idle", int'(pcop), 0);
        end
      end
    end
    prev_en = en_vec;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mem_ready = 1'b0; jmpbranch = 1'b0; instr = 16'h0000;
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_instr(16'h0244, 0, 0, 1'b0, 0);
    run_instr(16'hC010, 0, 0, 1'b1, 0);
    run_instr(16'h0A6C, 1, 0, 1'b1, 0);
    run_instr(16'hF000, 0, 3, 1'b0, 0);
    run_instr(16'hD0FF, 2, 0, 1'b0, 0);
    run_instr(16'hE3A5, 0, 0, 1'b1, 0);

    // reset while waiting on a data access
    wk = 0;
    while (!en_fetch && wk < 40) begin @(negedge clk); wk++; end
    exp_q.push_back(model(16'hE123, 1'b0, 0));
    mem_ready = 1'b1; instr = 16'hE123;
    @(negedge clk);
    mem_ready = 1'b0;
    wk = 0;
    while (!en_mem && wk < 20) begin @(negedge clk); wk++; end
    if (!en_mem) fail_now("mem_entry_timeout");
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("fetch_after_reset", int'(en_fetch), 1);

    run_instr(16'h1234, 0, 0, 1'b0, 3);
    run_instr(16'h7FFF, 0, 0, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      run_instr(16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
